// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold/bubble encodings, per-stage bit indices and the
// controller FSM state encoding.
package pipe_ctrl_pkg;

  localparam logic StallYes = 1'b1;
  localparam logic StallNo  = 1'b0;

  localparam int StallBus = 5;

  localparam int StgPc    = 0;
  localparam int StgIfId  = 1;
  localparam int StgIdEx  = 2;
  localparam int StgExMem = 3;
  localparam int StgMemWb = 4;

  // Each request class holds every register upstream of the stalling stage and
  // injects a bubble into the register right after it.
  localparam logic [StallBus-1:0] MemStallVec  = 5'b01111;
  localparam logic [StallBus-1:0] MemBubbleVec = 5'b10000;
  localparam logic [StallBus-1:0] ExStallVec   = 5'b00111;
  localparam logic [StallBus-1:0] ExBubbleVec  = 5'b01000;
  localparam logic [StallBus-1:0] IdStallVec   = 5'b00011;
  localparam logic [StallBus-1:0] IdBubbleVec  = 5'b00100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Stall/bubble controller for the five-stage pipe; MEM > EX > ID priority, PIPE_CTRL_TIMEOUT_EN adds a memory watchdog.
// Latency: zero cycles from request to stall; FSM state follows one edge later.
// Backpressure: holds upstream registers while a wait is open, releases in the ack/done cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stallreq,
  input  logic                ex_mc_start,
  input  logic                ex_mc_done,
  input  logic                mem_req,
  input  logic                mem_ack,
  output logic [StallBus-1:0] stall,
  output logic [StallBus-1:0] bubble,
  output logic                mem_err
);

  pipe_state_e state_q, state_d;
  logic        wd_fire;
  logic        mem_wait;
  logic        ex_wait;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [CNT_W:0] TimeoutCmp = (CNT_W+1)'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The cycle that raised mem_req is not counted in MEM_WAIT, hence the +1.
  assign wd_fire = (state_q == ST_MEM_WAIT) && !mem_ack &&
                   (({1'b0, cnt_q} + (CNT_W+1)'(1)) == TimeoutCmp);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && state_d == ST_MEM_WAIT) begin
      cnt_d = '0;
    end else if (state_q == ST_MEM_WAIT && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [CNT_W-1:0] unused_timeout;
  assign unused_timeout = CNT_W'(MEM_TIMEOUT);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mem_wait = !mem_ack && !wd_fire && (mem_req || state_q == ST_MEM_WAIT);
    ex_wait  = !ex_mc_done && (ex_mc_start || state_q == ST_MC_WAIT);

    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_ack) begin
          state_d = ST_MEM_WAIT;
        end else if (ex_mc_start && !ex_mc_done) begin
          state_d = ST_MC_WAIT;
        end
      end
      ST_MC_WAIT: begin
        if (ex_mc_done) state_d = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (mem_ack || wd_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall   = '0;
    bubble  = '0;
    mem_err = 1'b0;
    if (rst) begin
      mem_err = wd_fire;
      if (mem_wait) begin
        stall  = MemStallVec;
        bubble = MemBubbleVec;
      end else if (ex_wait) begin
        stall  = ExStallVec;
        bubble = ExBubbleVec;
      end else if (id_stallreq) begin
        stall  = IdStallVec;
        bubble = IdBubbleVec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle drives inputs, checks the combinational
// stall/bubble/mem_err mid-cycle against hand-computed vectors, then advances the clock.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_stallreq, ex_mc_start, ex_mc_done, mem_req, mem_ack;
  logic [4:0] stall, bubble;
  logic       mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] S_MEM = 5'b01111, B_MEM = 5'b10000;
  localparam logic [4:0] S_EX  = 5'b00111, B_EX  = 5'b01000;
  localparam logic [4:0] S_ID  = 5'b00011, B_ID  = 5'b00100;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_stallreq (id_stallreq),
    .ex_mc_start (ex_mc_start),
    .ex_mc_done  (ex_mc_done),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .bubble      (bubble),
    .mem_err     (mem_err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Drive one cycle of inputs, let them settle, compare outputs, then step past the edge.
  task automatic cyc(input string tag, input logic r, input logic id, input logic st,
                     input logic dn, input logic rq, input logic ak,
                     input logic [4:0] exp_s, input logic [4:0] exp_b, input logic exp_e);
    rst = r; id_stallreq = id; ex_mc_start = st; ex_mc_done = dn; mem_req = rq; mem_ack = ak;
    #2;
    check({tag, ".stall"},   {3'b0, stall},  {3'b0, exp_s});
    check({tag, ".bubble"},  {3'b0, bubble}, {3'b0, exp_b});
    check({tag, ".mem_err"}, {7'b0, mem_err}, {7'b0, exp_e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; id_stallreq = 0; ex_mc_start = 0; ex_mc_done = 0; mem_req = 0; mem_ack = 0;
    @(posedge clk);
    #1;
    // reset forces outputs low even with requests present
    cyc("rst_idle",  0, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);
    cyc("rst_force", 0, 1, 1, 0, 1, 0, 5'b0, 5'b0, 0);
    cyc("rst_rel",   1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // ID hazard, two cycles, never latched
    cyc("id_c0", 1, 1, 0, 0, 0, 0, S_ID, B_ID, 0);
    cyc("id_c1", 1, 1, 0, 0, 0, 0, S_ID, B_ID, 0);
    cyc("id_c2", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // multi-cycle op: start at 0, done at 4, ID request at 2 masked
    cyc("mc_c0", 1, 0, 1, 0, 0, 0, S_EX, B_EX, 0);
    cyc("mc_c1", 1, 0, 0, 0, 0, 0, S_EX, B_EX, 0);
    cyc("mc_c2", 1, 1, 0, 0, 0, 0, S_EX, B_EX, 0);
    cyc("mc_c3", 1, 0, 0, 0, 0, 0, S_EX, B_EX, 0);
    cyc("mc_c4", 1, 0, 0, 1, 0, 0, 5'b0, 5'b0, 0);
    cyc("mc_c5", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // memory wait with ack at 3, ex_mc_start at 1 masked and not latched
    cyc("mem_c0", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("mem_c1", 1, 0, 1, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("mem_c2", 1, 1, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("mem_c3", 1, 0, 0, 0, 1, 1, 5'b0, 5'b0, 0);
    cyc("mem_c4", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // reset during MEM_WAIT abandons the wait
    cyc("rmw_c0", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("rmw_c1", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("rmw_c2", 0, 0, 0, 0, 1, 0, 5'b0, 5'b0, 0);
    cyc("rmw_c3", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);
    cyc("rmw_c4", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // start and done together: no stall, FSM stays idle
    cyc("sd_c0", 1, 0, 1, 1, 0, 0, 5'b0, 5'b0, 0);
    cyc("sd_c1", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);
    cyc("sd_c2", 1, 1, 0, 0, 0, 0, S_ID, B_ID, 0);

    // stray ack while idle is ignored
    cyc("ack_idle", 1, 0, 0, 0, 0, 1, 5'b0, 5'b0, 0);
    cyc("ack_post", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);

    // memory access with no ack: watchdog at 4 if compiled in, else held until ack
    cyc("wd_c0", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("wd_c1", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("wd_c2", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("wd_c3", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
`ifdef PIPE_CTRL_TIMEOUT_EN
    cyc("wd_c4", 1, 0, 0, 0, 1, 0, 5'b0, 5'b0, 1);
    cyc("wd_c5", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);
`else
    cyc("wd_c4", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("wd_c5", 1, 0, 0, 0, 1, 0, S_MEM, B_MEM, 0);
    cyc("wd_c6", 1, 0, 0, 0, 0, 0, S_MEM, B_MEM, 0);
    cyc("wd_c7", 1, 0, 0, 0, 0, 1, 5'b0, 5'b0, 0);
    cyc("wd_c8", 1, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/bubble controller for the five-stage core: the single driver of the `stall` inputs of every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) and of their bubble-load inputs. It arbitrates stall requests from ID (load-use hazard), EX (multi-cycle mul/div) and MEM (slow memory bus), tracks multi-cycle and memory waits with a small FSM, and drains the pipe cleanly on release. Pipeline registers only honour the vectors; all hazard policy lives here.

## Interface
- MEM_TIMEOUT, 255: cycles a memory access may wait for `mem_ack` before the watchdog fires (only with watchdog compiled in).
- CNT_W, 8: width of the wait counter; MEM_TIMEOUT must fit in CNT_W bits.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge).
- id_stallreq  in  1  level; ID detected load-use hazard this cycle.
- ex_mc_start  in  1  one-cycle pulse; EX began a multi-cycle op.
- ex_mc_done  in  1  one-cycle pulse; multi-cycle result valid this cycle.
- mem_req  in  1  level; MEM stage has a load/store in flight.
- mem_ack  in  1  one-cycle pulse from memory bus; access completes this cycle.
- stall  out  5  hold vector, bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold (`StallYes`).
- bubble  out  5  same bit order; 1 = register loads NOP/`WriteDisable` at next edge.
- mem_err  out  1  one-cycle pulse: watchdog expired (always 0 without watchdog).

## Operation
- FSM states: IDLE, MC_WAIT, MEM_WAIT.
- IDLE -> MEM_WAIT: mem_req=1, mem_ack=0. IDLE -> MC_WAIT: ex_mc_start=1 and MEM condition false. Otherwise stay.
- MC_WAIT -> IDLE on ex_mc_done; MC_WAIT -> MEM_WAIT never (EX holds no memory op while busy).
- MEM_WAIT -> IDLE on mem_ack (or watchdog expiry).
- Request classes, priority MEM > EX > ID (highest wins, lower ones masked that cycle):
  - MEM wait (mem_req & !mem_ack, or state MEM_WAIT & !mem_ack): stall=5'b01111, bubble=5'b10000.
  - EX wait (ex_mc_start, or state MC_WAIT & !ex_mc_done): stall=5'b00111, bubble=5'b01000.
  - ID hazard (id_stallreq): stall=5'b00011, bubble=5'b00100.
  - none: stall=0, bubble=0.
- Outputs are combinational from current state and inputs so a request stalls in the same cycle it is raised.
- Release cycle (mem_ack or ex_mc_done asserted): that class no longer contributes; lower-priority requests in the same cycle are evaluated normally.
- Wait counter: cleared on entry to MEM_WAIT, +1 per cycle in MEM_WAIT, saturates at 2^CNT_W-1.
- rst=0: stall and bubble forced to 0 combinationally, mem_err=0; on edge state=IDLE, counter=0. Reset mid-wait abandons the wait; no release pulse required afterwards.

## Timing
- Zero-cycle request-to-stall latency; FSM state updates one edge after the triggering input.
- Memory access with ack on cycle k after mem_req rise: stall asserted cycles 0..k-1, released in cycle k.
- ex_mc_start at cycle 0, ex_mc_done at cycle n: stall asserted cycles 0..n-1.
- ex_mc_start and ex_mc_done in the same cycle: treated as done; state stays IDLE, no stall.
- mem_ack while in IDLE with mem_req=0: ignored.
- id_stallreq is never latched; it stalls only in cycles it is high.

## Configuration
- PIPE_CTRL_TIMEOUT_EN defined: in MEM_WAIT, when counter reaches MEM_TIMEOUT without mem_ack, mem_err pulses for one cycle, state -> IDLE, stall released that cycle; MEM stage treats it as a completed access.
- Undefined: no watchdog, mem_err tied 0, MEM_WAIT persists until mem_ack; counter may be omitted.

## Structure
- Shared defines file gets: `StallYes`/`StallNo`, stall/bubble vector width (`StallBus`), bit-index names per stage, FSM state encodings.
- Single module, no sub-modules; optional watchdog counter inline under the macro.

## Test plan
- id_stallreq high 2 cycles, all else 0 -> stall=00011, bubble=00100 both cycles, then 0.
- ex_mc_start at cycle 0, ex_mc_done at cycle 4 -> stall=00111 cycles 0-3, 0 at cycle 4; id_stallreq high at cycle 2 changes nothing.
- mem_req rise with mem_ack at cycle 3 and ex_mc_start at cycle 1 -> stall=01111/bubble=10000 cycles 0-2, ex_mc_start masked, 0 at cycle 3.
- rst=0 during MEM_WAIT cycle 2 -> outputs 0 immediately; after rst=1, mem_req=0 -> IDLE, stall=0.
- With PIPE_CTRL_TIMEOUT_EN, MEM_TIMEOUT=4, no ack -> stall cycles 0-3, mem_err pulse and release at cycle 4; without macro, stall held until ack.
- ex_mc_start and ex_mc_done same cycle -> stall=0, state remains IDLE.
